// File: rtl/inst_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pkg
// Shared constants and types for the instruction-fetch front end:
//   - reset PC, zero word, exception codes, stall/flush levels
//   - fetch FSM state encoding (if_state_e)
//   - pc_aligned(): word-alignment test on a fetch address
// -----------------------------------------------------------------------------
package inst_fetch_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int EXC_CODE_W  = 5;

    localparam logic [INST_ADDR_W-1:0] PC_INIT   = 32'hBFC0_0000;
    localparam logic [31:0]            ZERO_WORD = 32'h0000_0000;

    localparam logic [EXC_CODE_W-1:0]  EXC_NONE  = 5'h10;
    localparam logic [EXC_CODE_W-1:0]  EXC_ADEL  = 5'h04;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;
    localparam logic FLUSH  = 1'b1;

    typedef enum logic [2:0] {
        IF_IDLE   = 3'd0,
        IF_WADDR  = 3'd1,
        IF_WDATA  = 3'd2,
        IF_HOLD   = 3'd3,
        IF_CANCEL = 3'd4
    } if_state_e;

    // A fetch address is legal only when it is word aligned.
    function automatic logic pc_aligned(input logic [INST_ADDR_W-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_if
// SRAM-like instruction-side port between the fetch controller and the bridge.
//   inst_req      : fetch request (master -> slave)
//   inst_addr     : fetch address (master -> slave)
//   inst_addr_ok  : address accepted (slave -> master)
//   inst_data_ok  : read data valid (slave -> master)
//   inst_rdata    : instruction word (slave -> master)
// -----------------------------------------------------------------------------
interface inst_fetch_ctrl_if;
    import inst_fetch_ctrl_pkg::*;

    logic                   inst_req;
    logic [INST_ADDR_W-1:0] inst_addr;
    logic                   inst_addr_ok;
    logic                   inst_data_ok;
    logic [31:0]            inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );

endinterface

// File: rtl/inst_fetch_ctrl_pc_redirect.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl_pc_redirect
// Holds the fetch PC and a pending branch redirect.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush/flush_pc : exception redirect, highest priority
//   branch_flag/branch_target : taken branch seen in ID (delay slot in flight)
//   consume        : the held instruction is taken by IF/ID this cycle
//   pc             : current fetch PC (registered)
//   pc_nxt         : value pc takes at the next edge
// -----------------------------------------------------------------------------
module inst_fetch_ctrl_pc_redirect
    import inst_fetch_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] flush_pc,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    input  logic                   consume,
    output logic [INST_ADDR_W-1:0] pc,
    output logic [INST_ADDR_W-1:0] pc_nxt
);

    logic [INST_ADDR_W-1:0] pc_r;
    logic [INST_ADDR_W-1:0] redirect_pc_r;
    logic                   redirect_pending_r;
    logic [INST_ADDR_W-1:0] redirect_pc_nxt_s;
    logic                   redirect_pending_nxt_s;

    // Next-PC priority: flush, then consume (fresh branch, pending redirect, +4).
    always_comb begin
        pc_nxt                 = pc_r;
        redirect_pc_nxt_s      = redirect_pc_r;
        redirect_pending_nxt_s = redirect_pending_r;
        if (flush == FLUSH) begin
            pc_nxt                 = flush_pc;
            redirect_pending_nxt_s = 1'b0;
        end else if (consume) begin
            // A branch resolved in the same cycle the delay slot leaves HOLD
            // must steer this very update.
            if (branch_flag) begin
                pc_nxt = branch_target;
            end else if (redirect_pending_r) begin
                pc_nxt = redirect_pc_r;
            end else begin
                pc_nxt = pc_r + 32'd4;
            end
            redirect_pending_nxt_s = 1'b0;
        end else if (branch_flag) begin
            redirect_pc_nxt_s      = branch_target;
            redirect_pending_nxt_s = 1'b1;
        end else begin
            redirect_pending_nxt_s = redirect_pending_r;
        end
    end

    // PC and redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r               <= PC_INIT;
            redirect_pc_r      <= ZERO_WORD;
            redirect_pending_r <= 1'b0;
        end else begin
            pc_r               <= pc_nxt;
            redirect_pc_r      <= redirect_pc_nxt_s;
            redirect_pending_r <= redirect_pending_nxt_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction-fetch front end: sequences the PC, issues SRAM-like fetches and
// presents the fetched word to the IF/ID register.
//   cpu_clk_50M, cpu_rst_n : clock, asynchronous active-low reset
//   stall        : pipeline stall vector, bit 1 is the IF/ID stall
//   flush, flush_pc        : exception flush and handler address
//   branch_flag, branch_target : taken branch/jump from ID
//   bus          : instruction-side SRAM-like port (master)
//   if_pc, if_inst, if_exccode : presented instruction (registered)
//   stallreq_if  : fetch not ready
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int STALL_W = 6
) (
    input  logic                   cpu_clk_50M,
    input  logic                   cpu_rst_n,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] flush_pc,
    input  logic                   branch_flag,
    input  logic [INST_ADDR_W-1:0] branch_target,
    inst_fetch_ctrl_if.master      bus,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [31:0]            if_inst,
    output logic [EXC_CODE_W-1:0]  if_exccode,
    output logic                   stallreq_if
);

    if_state_e              state_r, state_nxt_s;
    logic                   cancel_owed_r, cancel_owed_nxt_s;
    logic                   consume_s;
    logic                   inst_req_r;
    logic                   stallreq_r, stallreq_nxt_s;
    logic [INST_ADDR_W-1:0] if_pc_r, if_pc_nxt_s;
    logic [31:0]            if_inst_r, if_inst_nxt_s;
    logic [EXC_CODE_W-1:0]  if_exc_r, if_exc_nxt_s;
    logic [INST_ADDR_W-1:0] pc_s, pc_nxt_s;
    logic                   unused_stall_s;

    assign unused_stall_s = ^{stall[STALL_W-1:2], stall[0]};

    inst_fetch_ctrl_pc_redirect u_pc_redirect (
        .clk           (cpu_clk_50M),
        .rst_n         (cpu_rst_n),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .consume       (consume_s),
        .pc            (pc_s),
        .pc_nxt        (pc_nxt_s)
    );

    // Fetch FSM next state and captured-instruction update.
    always_comb begin
        state_nxt_s       = state_r;
        cancel_owed_nxt_s = cancel_owed_r;
        consume_s         = 1'b0;
        if_pc_nxt_s       = if_pc_r;
        if_inst_nxt_s     = if_inst_r;
        if_exc_nxt_s      = if_exc_r;
        if (flush == FLUSH) begin
            if_inst_nxt_s = ZERO_WORD;
            if_exc_nxt_s  = EXC_NONE;
            case (state_r)
                // The request cannot be withdrawn; remember to drop its data.
                IF_WADDR: begin
                    if (bus.inst_addr_ok) begin
                        state_nxt_s       = IF_CANCEL;
                        cancel_owed_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s       = IF_WADDR;
                        cancel_owed_nxt_s = 1'b1;
                    end
                end
                IF_WDATA, IF_CANCEL: begin
                    state_nxt_s = bus.inst_data_ok ? IF_IDLE : IF_CANCEL;
                end
                default: begin
                    state_nxt_s = IF_IDLE;
                end
            endcase
        end else begin
            case (state_r)
                IF_IDLE: begin
                    if (pc_aligned(pc_s)) begin
                        state_nxt_s = IF_WADDR;
                    end else begin
                        if_pc_nxt_s   = pc_s;
                        if_inst_nxt_s = ZERO_WORD;
                        if_exc_nxt_s  = EXC_ADEL;
                        state_nxt_s   = IF_HOLD;
                    end
                end
                IF_WADDR: begin
                    if (bus.inst_addr_ok) begin
                        state_nxt_s       = cancel_owed_r ? IF_CANCEL : IF_WDATA;
                        cancel_owed_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = IF_WADDR;
                    end
                end
                IF_WDATA: begin
                    if (bus.inst_data_ok) begin
                        if_pc_nxt_s   = pc_s;
                        if_inst_nxt_s = bus.inst_rdata;
                        if_exc_nxt_s  = EXC_NONE;
                        state_nxt_s   = IF_HOLD;
                    end else begin
                        state_nxt_s = IF_WDATA;
                    end
                end
                IF_HOLD: begin
                    if (stall[1] == NOSTOP) begin
                        consume_s   = 1'b1;
                        state_nxt_s = IF_IDLE;
                    end else begin
                        state_nxt_s = IF_HOLD;
                    end
                end
                IF_CANCEL: begin
                    if (bus.inst_data_ok) begin
                        state_nxt_s = IF_IDLE;
                    end else begin
                        state_nxt_s = IF_CANCEL;
                    end
                end
                default: begin
                    state_nxt_s       = IF_IDLE;
                    cancel_owed_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Stall request for the state being entered, so it can be registered.
    always_comb begin
        case (state_nxt_s)
            IF_IDLE:  stallreq_nxt_s = pc_aligned(pc_nxt_s);
            IF_HOLD:  stallreq_nxt_s = 1'b0;
            default:  stallreq_nxt_s = 1'b1;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_r       <= IF_IDLE;
            cancel_owed_r <= 1'b0;
            inst_req_r    <= 1'b0;
            stallreq_r    <= 1'b1;
            if_pc_r       <= PC_INIT;
            if_inst_r     <= ZERO_WORD;
            if_exc_r      <= EXC_NONE;
        end else begin
            state_r       <= state_nxt_s;
            cancel_owed_r <= cancel_owed_nxt_s;
            inst_req_r    <= (state_nxt_s == IF_WADDR);
            stallreq_r    <= stallreq_nxt_s;
            if_pc_r       <= if_pc_nxt_s;
            if_inst_r     <= if_inst_nxt_s;
            if_exc_r      <= if_exc_nxt_s;
        end
    end

    assign bus.inst_req  = inst_req_r;
    assign bus.inst_addr = pc_s;
    assign if_pc         = if_pc_r;
    assign if_inst       = if_inst_r;
    assign if_exccode    = if_exc_r;
    assign stallreq_if   = stallreq_r;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Directed bench for inst_fetch_ctrl. Inputs are driven and outputs sampled on
// the falling clock edge; the bridge side is driven by hand, cycle by cycle.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic [5:0]  stall       = 6'b0;
    logic        flush       = 1'b0;
    logic [31:0] flush_pc    = 32'h0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [4:0]  if_exccode;
    logic        stallreq_if;
    int          n_run  = 0;
    int          n_fail = 0;

    inst_fetch_ctrl_if bus ();

    always #5 cpu_clk_50M = ~cpu_clk_50M;

    inst_fetch_ctrl #(.STALL_W(6)) dut (
        .cpu_clk_50M   (cpu_clk_50M),
        .cpu_rst_n     (cpu_rst_n),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .bus           (bus),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_exccode    (if_exccode),
        .stallreq_if   (stallreq_if)
    );

    task automatic tick();
        @(negedge cpu_clk_50M);
    endtask

    // Zero-wait fetch starting from IDLE; ends in HOLD.
    task automatic do_fetch(input logic [31:0] word);
        tick();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = word;
        tick();
        bus.inst_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        bus.inst_addr_ok = 1'b1;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        cpu_rst_n = 1'b0;
        tick(); tick();
        n_run++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %h exp 0", bus.inst_req); end
        n_run++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL rst_stallreq: got %h exp 1", stallreq_if); end
        n_run++; if (bus.inst_addr !== 32'hBFC00000) begin n_fail++; $display("FAIL rst_addr: got %h exp bfc00000", bus.inst_addr); end
        n_run++; if (if_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL rst_if_pc: got %h exp bfc00000", if_pc); end
        n_run++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL rst_if_inst: got %h exp 0", if_inst); end
        n_run++; if (if_exccode !== EXC_NONE) begin n_fail++; $display("FAIL rst_exc: got %h exp %h", if_exccode, EXC_NONE); end
        cpu_rst_n = 1'b1;
        tick();
        n_run++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_cycle1: got %h exp 1", bus.inst_req); end
        n_run++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL rst_stallreq_cycle1: got %h exp 1", stallreq_if); end
    endtask

    task automatic test_basic_fetch();
        tick();
        bus.inst_addr_ok = 1'b0;
        n_run++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %h exp 0", bus.inst_req); end
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h24010005;
        tick();
        bus.inst_data_ok = 1'b0;
        n_run++; if (if_pc !== 32'hBFC00000) begin n_fail++; $display("FAIL basic_if_pc: got %h exp bfc00000", if_pc); end
        n_run++; if (if_inst !== 32'h24010005) begin n_fail++; $display("FAIL basic_if_inst: got %h exp 24010005", if_inst); end
        n_run++; if (stallreq_if !== 1'b0) begin n_fail++; $display("FAIL basic_hold_stallreq: got %h exp 0", stallreq_if); end
        tick();
        n_run++; if (bus.inst_addr !== 32'hBFC00004) begin n_fail++; $display("FAIL basic_next_addr: got %h exp bfc00004", bus.inst_addr); end
        n_run++; if (stallreq_if !== 1'b1) begin n_fail++; $display("FAIL basic_idle_stallreq: got %h exp 1", stallreq_if); end
    endtask

    task automatic test_stall();
        stall = 6'b000010;
        do_fetch(32'h8C220000);
        for (int i = 0; i < 4; i++) begin
            n_run++; if (if_inst !== 32'h8C220000 || if_pc !== 32'hBFC00004) begin n_fail++; $display("FAIL stall_hold_out[%0d]: got %h/%h exp bfc00004/8c220000", i, if_pc, if_inst); end
            n_run++; if (bus.inst_req !== 1'b0 || stallreq_if !== 1'b0) begin n_fail++; $display("FAIL stall_hold_ctl[%0d]: got req %h stallreq %h exp 0/0", i, bus.inst_req, stallreq_if); end
            n_run++; if (bus.inst_addr !== 32'hBFC00004) begin n_fail++; $display("FAIL stall_hold_addr[%0d]: got %h exp bfc00004", i, bus.inst_addr); end
            tick();
        end
        stall = 6'b000000;
        tick();
        n_run++; if (bus.inst_addr !== 32'hBFC00008) begin n_fail++; $display("FAIL stall_release_addr: got %h exp bfc00008", bus.inst_addr); end
    endtask

    task automatic test_branch();
        tick();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        branch_flag      = 1'b1;
        branch_target    = 32'hBFC00100;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h00851021;
        tick();
        branch_flag      = 1'b0;
        bus.inst_data_ok = 1'b0;
        n_run++; if (if_pc !== 32'hBFC00008) begin n_fail++; $display("FAIL branch_slot_pc: got %h exp bfc00008", if_pc); end
        n_run++; if (if_inst !== 32'h00851021) begin n_fail++; $display("FAIL branch_slot_inst: got %h exp 00851021", if_inst); end
        tick();
        n_run++; if (bus.inst_addr !== 32'hBFC00100) begin n_fail++; $display("FAIL branch_target_addr: got %h exp bfc00100", bus.inst_addr); end
    endtask

    task automatic test_flush_wdata();
        tick();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'hBFC00380;
        tick();
        flush = 1'b0;
        n_run++; if (bus.inst_addr !== 32'hBFC00380) begin n_fail++; $display("FAIL fwd_addr: got %h exp bfc00380", bus.inst_addr); end
        n_run++; if (bus.inst_req !== 1'b0 || stallreq_if !== 1'b1) begin n_fail++; $display("FAIL fwd_cancel_ctl: got req %h stallreq %h exp 0/1", bus.inst_req, stallreq_if); end
        tick();
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hDEADBEEF;
        tick();
        bus.inst_data_ok = 1'b0;
        n_run++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL fwd_stale_inst: got %h exp 0", if_inst); end
        n_run++; if (bus.inst_req !== 1'b0 || stallreq_if !== 1'b1) begin n_fail++; $display("FAIL fwd_idle_ctl: got req %h stallreq %h exp 0/1", bus.inst_req, stallreq_if); end
        tick();
        n_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC00380) begin n_fail++; $display("FAIL fwd_refetch: got req %h addr %h exp 1/bfc00380", bus.inst_req, bus.inst_addr); end
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h40086000;
        tick();
        bus.inst_data_ok = 1'b0;
        n_run++; if (if_pc !== 32'hBFC00380 || if_inst !== 32'h40086000) begin n_fail++; $display("FAIL fwd_handler_inst: got %h/%h exp bfc00380/40086000", if_pc, if_inst); end
        tick();
    endtask

    task automatic test_flush_waddr();
        tick();
        n_run++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL fwa_req: got %h exp 1", bus.inst_req); end
        flush    = 1'b1;
        flush_pc = 32'hBFC00400;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_run++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL fwa_req_held[%0d]: got %h exp 1", i, bus.inst_req); end
            tick();
        end
        n_run++; if (bus.inst_req !== 1'b1) begin n_fail++; $display("FAIL fwa_req_held[2]: got %h exp 1", bus.inst_req); end
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        n_run++; if (bus.inst_req !== 1'b0 || stallreq_if !== 1'b1) begin n_fail++; $display("FAIL fwa_cancel_ctl: got req %h stallreq %h exp 0/1", bus.inst_req, stallreq_if); end
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'hBADBAD00;
        tick();
        bus.inst_data_ok = 1'b0;
        n_run++; if (if_inst !== 32'h0 || stallreq_if !== 1'b1) begin n_fail++; $display("FAIL fwa_drop: got inst %h stallreq %h exp 0/1", if_inst, stallreq_if); end
        tick();
        n_run++; if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC00400) begin n_fail++; $display("FAIL fwa_refetch: got req %h addr %h exp 1/bfc00400", bus.inst_req, bus.inst_addr); end
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h3C1A8000;
        tick();
        bus.inst_data_ok = 1'b0;
        n_run++; if (if_pc !== 32'hBFC00400 || if_inst !== 32'h3C1A8000) begin n_fail++; $display("FAIL fwa_handler_inst: got %h/%h exp bfc00400/3c1a8000", if_pc, if_inst); end
        tick();
    endtask

    task automatic test_misaligned();
        tick();
        bus.inst_addr_ok = 1'b1;
        tick();
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = 32'h00000000;
        branch_flag      = 1'b1;
        branch_target    = 32'hBFC00102;
        tick();
        bus.inst_data_ok = 1'b0;
        branch_flag      = 1'b0;
        tick();
        n_run++; if (bus.inst_addr !== 32'hBFC00102 || stallreq_if !== 1'b0) begin n_fail++; $display("FAIL mis_idle: got addr %h stallreq %h exp bfc00102/0", bus.inst_addr, stallreq_if); end
        tick();
        n_run++; if (bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %h exp 0", bus.inst_req); end
        n_run++; if (if_exccode !== EXC_ADEL) begin n_fail++; $display("FAIL mis_exc: got %h exp %h", if_exccode, EXC_ADEL); end
        n_run++; if (if_inst !== 32'h0 || if_pc !== 32'hBFC00102) begin n_fail++; $display("FAIL mis_out: got %h/%h exp bfc00102/0", if_pc, if_inst); end
        // branch coinciding with the consume steers this very PC update
        branch_flag   = 1'b1;
        branch_target = 32'hBFC00200;
        tick();
        branch_flag = 1'b0;
        n_run++; if (bus.inst_addr !== 32'hBFC00200) begin n_fail++; $display("FAIL coinc_branch_addr: got %h exp bfc00200", bus.inst_addr); end
    endtask

    task automatic test_wrap_priority();
        flush         = 1'b1;
        flush_pc      = 32'hFFFFFFFC;
        branch_flag   = 1'b1;
        branch_target = 32'hBFC00500;
        tick();
        flush       = 1'b0;
        branch_flag = 1'b0;
        n_run++; if (bus.inst_addr !== 32'hFFFFFFFC || bus.inst_req !== 1'b0) begin n_fail++; $display("FAIL prio_flush: got addr %h req %h exp fffffffc/0", bus.inst_addr, bus.inst_req); end
        do_fetch(32'h1000FFFF);
        n_run++; if (if_pc !== 32'hFFFFFFFC || if_exccode !== EXC_NONE) begin n_fail++; $display("FAIL wrap_if_pc: got %h/%h exp fffffffc/%h", if_pc, if_exccode, EXC_NONE); end
        tick();
        n_run++; if (bus.inst_addr !== 32'h00000000) begin n_fail++; $display("FAIL wrap_addr: got %h exp 0", bus.inst_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge cpu_clk_50M);
        test_reset();
        test_basic_fetch();
        test_stall();
        test_branch();
        test_flush_wdata();
        test_flush_waddr();
        test_misaligned();
        test_wrap_priority();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
